// File: rtl/mips_ctrl_pkg.sv
// Shared control encodings for the multi-cycle MIPS core.
// Holds the controller state encoding (4-bit), the opcode constants and the
// alu_op / alu_src_b / pc_src encodings used by the datapath muxes and the ALU
// decoder.
// Configuration macro: MC_BNE_EN adds the BNE_EX state.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJEx     = 4'd11,
`ifdef MC_BNE_EN
        StFault   = 4'd12,
        StBneEx   = 4'd13
`else
        StFault   = 4'd12
`endif
    } state_e;

    // Opcodes, instruction bits [31:26]
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    // alu_op
    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    // alu_src_b
    localparam logic [1:0] SrcBRt     = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    // pc_src
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer.
// Counts consecutive cycles a memory access has been stalled and flags the
// cycle on which the count would reach TIMEOUT_CYCLES.
// Ports:
//   clk_i      core clock
//   rst_i      synchronous active-high reset
//   clr_i      clear the count (has priority over inc_i)
//   inc_i      one more stalled cycle
//   expired_o  this stalled cycle is the TIMEOUT_CYCLES-th in a row
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A ready memory clears the count, so completion on the last cycle wins.
    assign expired_o = inc_i && !clr_i && (cnt_q == LastCnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control unit of the multi-cycle MIPS core.
// Decodes the opcode across states and drives every datapath strobe and mux
// select; waits on mem_ready in FETCH/MEMRD/MEMWR and faults after
// TIMEOUT_CYCLES consecutive stalled cycles. Only rst leaves FAULT.
// Configuration macro: MC_BNE_EN enables bne (opcode 000101) via BNE_EX.
// Ports:
//   clk, rst (sync, active high), opcode, zero, mem_ready   inputs
//   mem_read, mem_write, ir_write, reg_write, pc_en          strobes
//   iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_src  selects
//   illegal_op (pulse in DECODE), fault (level in FAULT)
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic       fault
);

    state_e state_q, state_d;
    logic   pc_write, branch;
    logic   in_wait, expired;
`ifdef MC_BNE_EN
    logic   branch_ne;
`endif

    assign in_wait = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (!in_wait || mem_ready),
        .inc_i    (in_wait && !mem_ready),
        .expired_o(expired)
    );

    always_comb begin
        state_d    = state_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
`ifdef MC_BNE_EN
        branch_ne  = 1'b0;
`endif
        iord       = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SrcBRt;
        alu_op     = AluAdd;
        pc_src     = PcSrcAlu;
        illegal_op = 1'b0;
        fault      = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcBFour;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)    state_d = StDecode;
                else if (expired) state_d = StFault;
            end
            StDecode: begin
                alu_src_b = SrcBImmSh2;
                unique case (opcode)
                    OpRtype:     state_d = StRtypeEx;
                    OpLw, OpSw:  state_d = StMemAdr;
                    OpBeq:       state_d = StBeqEx;
                    OpAddi:      state_d = StAddiEx;
                    OpJ:         state_d = StJEx;
`ifdef MC_BNE_EN
                    OpBne:       state_d = StBneEx;
`endif
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAdr, StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                if (state_q == StAddiEx) state_d = StAddiWb;
                else state_d = (opcode == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)    state_d = StMemWb;
                else if (expired) state_d = StFault;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready)    state_d = StFetch;
                else if (expired) state_d = StFault;
            end
            StRtypeEx: begin
                alu_src_a = 1'b1;
                alu_op    = AluFunct;
                state_d   = StRtypeWb;
            end
            StRtypeWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = StFetch;
            end
            StBeqEx: begin
                alu_src_a = 1'b1;
                alu_op    = AluSub;
                pc_src    = PcSrcAluOut;
                branch    = 1'b1;
                state_d   = StFetch;
            end
`ifdef MC_BNE_EN
            StBneEx: begin
                alu_src_a = 1'b1;
                alu_op    = AluSub;
                pc_src    = PcSrcAluOut;
                branch_ne = 1'b1;
                state_d   = StFetch;
            end
`endif
            StAddiWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StJEx: begin
                pc_src   = PcSrcJump;
                pc_write = 1'b1;
                state_d  = StFetch;
            end
            StFault: begin
                fault = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

`ifdef MC_BNE_EN
    assign pc_en = pc_write | (branch & zero) | (branch_ne & ~zero);
`else
    assign pc_en = pc_write | (branch & zero);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Main control unit of the multi-cycle MIPS core. Decodes the 6-bit opcode across states and drives every datapath strobe and every 2:1/4:1 multiplexer select (PC source, ALU operands, register-destination, write-back source, memory address source). Waits on a memory-ready handshake, times out stuck accesses into a fault state, and owns the PC-enable equation.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum consecutive wait cycles (`mem_ready`=0) in any memory state before faulting; legal range 2..255.
- `clk` in 1: single core clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: instruction bits [31:26] from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: instruction register load.
- `reg_write` out 1: register file write.
- `pc_en` out 1: PC register load.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_to_reg` out 1: write-back select (0 = ALUOut, 1 = MDR).
- `reg_dst` out 1: destination select (0 = rt, 1 = rd).
- `alu_src_a` out 1: 0 = PC, 1 = rs.
- `alu_src_b` out 2: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = funct decode.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `fault` out 1: high while in FAULT.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB, BEQ_EX, ADDI_EX, ADDI_WB, J_EX, FAULT.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00. Remains in FETCH while `mem_ready`=0. When `mem_ready`=1, `ir_write`=1 and the PC write strobe is 1 in that same cycle, then go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Next state by opcode:
  - 000000 → RTYPE_EX
  - 100011 and 101011 → MEMADR
  - 000100 → BEQ_EX
  - 001000 → ADDI_EX
  - 000010 → J_EX
  - any other → FETCH with `illegal_op`=1
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`=1, `iord`=1. Waits for `mem_ready`, then MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Then FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Held until `mem_ready`, then FETCH.
- RTYPE_EX: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Then RTYPE_WB (`reg_write`=1, `reg_dst`=1, `mem_to_reg`=0). Then FETCH.
- BEQ_EX: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, branch strobe=1. Then FETCH.
- ADDI_EX: as MEMADR. Then ADDI_WB (`reg_write`=1, `reg_dst`=0, `mem_to_reg`=0). Then FETCH.
- J_EX: `pc_src`=10, PC write strobe=1. Then FETCH.
- `pc_en` = pc_write | (branch & zero), computed combinationally.
- Timeout: a wait counter clears on entering FETCH, MEMRD or MEMWR and whenever `mem_ready`=1. It increments each cycle in those states while `mem_ready`=0. On reaching `TIMEOUT_CYCLES`, go to FAULT.
- FAULT: all strobes 0, selects 0, `fault`=1. Only `rst` exits FAULT.
- Any output not listed for a state is 0.

## Timing
- Outputs are combinational from state, plus `mem_ready` in wait states, plus `zero` for `pc_en`. Next state is registered.
- After `rst`: state=FETCH, counter=0, `fault`=0, `illegal_op`=0.
  - Because of the mem_ready term, the FETCH outputs in the first cycle are `mem_read`=1, `alu_src_b`=01, and `ir_write`/`pc_en` = `mem_ready`.
- `rst` asserted in any state, including mid-wait or FAULT, returns to FETCH on the next edge.
- Cycle counts with zero-wait memory:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
- Each memory wait cycle adds 1.
- `mem_ready`=1 on the same edge the counter would reach `TIMEOUT_CYCLES`: completion wins, no fault.

## Configuration
- `MC_BNE_EN` defined: opcode 000101 goes DECODE → BNE_EX.
  - BNE_EX has the same selects as BEQ_EX.
  - `pc_en` = pc_write | (branch & zero) | (branch_ne & ~zero).
- `MC_BNE_EN` undefined: 000101 is illegal (`illegal_op` pulse, return to FETCH), and the BNE_EX state is not built.

## Structure
- Shared package/header `mips_ctrl_pkg` holds:
  - state encodings (4-bit)
  - opcode constants
  - `alu_op`, `alu_src_b` and `pc_src` encodings
  - shared by the datapath muxes and the ALU decoder.
- One sub-module `mem_wait_timer`: clear/increment counter with a `TIMEOUT_CYCLES` compare, width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Reset, `mem_ready`=1, opcode 100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; `reg_write`=1 with `mem_to_reg`=1 only in cycle 5.
- Opcode 000100: with `zero`=1 → `pc_en`=1 and `pc_src`=01 in cycle 3; with `zero`=0 → `pc_en`=0.
- FETCH with `mem_ready` low for 3 cycles, then high → `ir_write` high exactly once, in cycle 4; no fault.
- `mem_ready` held 0 with `TIMEOUT_CYCLES`=16 → FAULT and `fault`=1 after 16 wait cycles, all strobes 0. `rst` then brings `mem_read`=1 in FETCH.
- Opcode 111111 → `illegal_op` 1-cycle pulse in DECODE, next state FETCH.
- Opcode 000101 with `zero`=0: macro on → `pc_en`=1 in BNE_EX; macro off → `illegal_op`=1.
